vx_mem_port_arb: RTL and testbench
==================================

Name: vx_mem_port_arb

Overview:
- Downstream neighbour of the cache top-level memory side.
- Merges the cache's MEM_PORTS line-sized memory request channels into one memory channel using round-robin arbitration.
- Appends the source port index to each request tag, and steers memory responses back to the originating port by decoding that index.
- Both directions are registered through 2-entry elastic buffers, so the cache and memory timing paths are decoupled.

Parameters:
- NUM_PORTS, 2: number of upstream cache memory ports; legal range 1..16.
- LINE_SIZE, 64: line size in bytes; data width is LINE_SIZE*8.
- ADDR_WIDTH, 26: line address width.
- TAG_IN_WIDTH, 8: upstream memory tag width.
- PORT_BITS, derived: $clog2(NUM_PORTS); 0 when NUM_PORTS==1.
- TAG_OUT_WIDTH, derived: TAG_IN_WIDTH+PORT_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_req_valid  in  [NUM_PORTS]x1  upstream request valid
- in_req_rw  in  [NUM_PORTS]x1  1 = write
- in_req_byteen  in  [NUM_PORTS]xLINE_SIZE  byte enables
- in_req_addr  in  [NUM_PORTS]xADDR_WIDTH  line address
- in_req_data  in  [NUM_PORTS]xLINE_SIZE*8  write data
- in_req_tag  in  [NUM_PORTS]xTAG_IN_WIDTH  request tag
- in_req_ready  out  [NUM_PORTS]x1  accept
- in_rsp_valid  out  [NUM_PORTS]x1  response valid
- in_rsp_data  out  [NUM_PORTS]xLINE_SIZE*8  read data
- in_rsp_tag  out  [NUM_PORTS]xTAG_IN_WIDTH  stripped tag
- in_rsp_ready  in  [NUM_PORTS]x1  upstream response accept
- mem_req_valid  out  1
- mem_req_rw  out  1
- mem_req_byteen  out  LINE_SIZE
- mem_req_addr  out  ADDR_WIDTH
- mem_req_data  out  LINE_SIZE*8
- mem_req_tag  out  TAG_OUT_WIDTH
- mem_req_ready  in  1
- mem_rsp_valid  in  1
- mem_rsp_data  in  LINE_SIZE*8
- mem_rsp_tag  in  TAG_OUT_WIDTH
- mem_rsp_ready  out  1

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is synchronous and active-high.
  - During reset: rr_ptr=0, both buffers empty; mem_req_valid=0, all in_rsp_valid=0, all in_req_ready=0, mem_rsp_ready=0.
  - Cycle after reset deasserts: in_req_ready may rise and mem_rsp_ready=1.
  - Reset mid-operation discards all buffered entries without emitting them.
- Request arbitration:
  - Combinational grant: the first valid port at index >= rr_ptr, wrapping modulo NUM_PORTS.
  - in_req_ready[g] = grant_valid && req_buf_not_full; all other in_req_ready are 0.
  - A grant is never withdrawn while unaccepted only if the buffer stays full. Upstream must hold valid and payload stable until ready.
- Pointer update:
  - On handshake, rr_ptr <= (g+1) mod NUM_PORTS.
  - rr_ptr is unchanged when there is no handshake.
  - Wrap from NUM_PORTS-1 to 0 is required.
- Request buffer:
  - 2-entry FIFO holding {rw, byteen, addr, data, tag_out}.
  - tag_out = {in_req_tag[g], g[PORT_BITS-1:0]}, with the port index in the LSBs.
  - Latency from accept to mem_req_valid is 1 cycle.
  - Sustains 1 request/cycle when mem_req_ready is held high.
  - Simultaneous push and pop while full is not allowed: the not_full check uses current occupancy.
  - Simultaneous push and pop with 1 entry keeps the count at 1.
- Response buffer:
  - 2-entry FIFO capturing mem_rsp when mem_rsp_valid && mem_rsp_ready; mem_rsp_ready = !full.
  - Head entry: p = tag[PORT_BITS-1:0].
  - in_rsp_valid[p]=1 and all others 0; in_rsp_data and in_rsp_tag are broadcast, with tag = head tag >> PORT_BITS.
  - Pop when in_rsp_ready[p]. Head-of-line blocking across ports is accepted.
  - Capture-to-valid latency is 1 cycle.
- Port index out of range (p >= NUM_PORTS): response is dropped (popped silently) and a simulation assertion fires.
- NUM_PORTS==1: rr_ptr is absent, the tag passes through unchanged, and both buffers are retained.
- Outputs are driven only from the buffer heads, with no combinational path from input valid to output valid.

Decomposition:
- Shared package (VX_gpu_pkg): mem_req_pkt_t, a packed struct {rw, byteen, addr, data, tag} parameterised via widths in the instantiating module; port-index helper macro for PORT_BITS.
- One natural sub-module: vx_elastic_buf2, a generic 2-entry valid/ready FIFO with data width parameter.
  - Instantiated twice: request and response.
  - Clear-on-reset.
  - full/empty flags exported.

Test Plan:
1. Reset held 3 cycles with all in_req_valid=1 -> mem_req_valid=0, in_req_ready=0, and mem_rsp_ready=0 throughout; mem_rsp_ready=1 on the first cycle after release.
2. NUM_PORTS=4, all ports valid continuously, mem_req_ready=1 -> mem_req_tag LSBs sequence 0,1,2,3,0,1…; one request per cycle; first mem_req_valid 1 cycle after the first accept.
3. Only port 2 valid with tag 0x5A -> mem_req_tag=(0x5A<<2)|2=0x16A; rr_ptr becomes 3, and a later port-0 request is granted next.
4. mem_req_ready=0 for 5 cycles with ports 0 and 1 valid -> exactly 2 requests accepted and further in_req_ready=0; on release, 2 drained in order with no loss or duplication.
5. Memory responses with tags 0x16A then 0x0C1, in_rsp_ready[2]=0 -> in_rsp_valid[2]=1 with tag 0x5A held; port 1 waits; mem_rsp_ready drops after the 2nd capture; releasing ready[2] delivers port 1 tag 0x30 next cycle.
6. Assert reset while both buffers hold 2 entries -> next cycle all valids 0, buffers empty, rr_ptr=0, no stale response emitted.

Source files
------------

// File: rtl/vx_mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter: port-index width helper and
// the request record used between the arbiter and its request buffer.
package vx_mem_port_arb_pkg;

    localparam int DEF_NUM_PORTS    = 2;
    localparam int DEF_LINE_SIZE    = 64;
    localparam int DEF_ADDR_WIDTH   = 26;
    localparam int DEF_TAG_IN_WIDTH = 8;

    // Number of tag bits needed to name a source port; a single port needs none.
    function automatic int port_bits(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 0;
    endfunction

    localparam int DEF_TAG_OUT_WIDTH = DEF_TAG_IN_WIDTH + port_bits(DEF_NUM_PORTS);

    // Request record at the default widths; the arbiter declares its own
    // copy sized from its parameters.
    typedef struct packed {
        logic                           rw;
        logic [DEF_LINE_SIZE-1:0]       byteen;
        logic [DEF_ADDR_WIDTH-1:0]      addr;
        logic [DEF_LINE_SIZE*8-1:0]     data;
        logic [DEF_TAG_OUT_WIDTH-1:0]   tag;
    } mem_req_pkt_t;

endpackage

// File: rtl/vx_elastic_buf2.sv
// Two-entry valid/ready FIFO. Push is accepted only when not full (current
// occupancy), pop only when not empty; contents are discarded on reset.
module vx_elastic_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign push     = push_valid && !full;
    assign pop      = pop_ready && !empty;
    assign pop_data = slot[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vx_mem_port_arb.sv
// Round-robin merge of NUM_PORTS cache memory channels onto one memory channel.
// The source port rides in the tag LSBs and steers the response back.
module vx_mem_port_arb
    import vx_mem_port_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int LINE_SIZE     = 64,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int PORT_BITS     = port_bits(NUM_PORTS),
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + PORT_BITS
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic [NUM_PORTS-1:0]                in_req_valid,
    input  logic [NUM_PORTS-1:0]                in_req_rw,
    input  logic [NUM_PORTS*LINE_SIZE-1:0]      in_req_byteen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     in_req_addr,
    input  logic [NUM_PORTS*LINE_SIZE*8-1:0]    in_req_data,
    input  logic [NUM_PORTS*TAG_IN_WIDTH-1:0]   in_req_tag,
    output logic [NUM_PORTS-1:0]                in_req_ready,

    output logic [NUM_PORTS-1:0]                in_rsp_valid,
    output logic [NUM_PORTS*LINE_SIZE*8-1:0]    in_rsp_data,
    output logic [NUM_PORTS*TAG_IN_WIDTH-1:0]   in_rsp_tag,
    input  logic [NUM_PORTS-1:0]                in_rsp_ready,

    output logic                                mem_req_valid,
    output logic                                mem_req_rw,
    output logic [LINE_SIZE-1:0]                mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr,
    output logic [LINE_SIZE*8-1:0]              mem_req_data,
    output logic [TAG_OUT_WIDTH-1:0]            mem_req_tag,
    input  logic                                mem_req_ready,

    input  logic                                mem_rsp_valid,
    input  logic [LINE_SIZE*8-1:0]              mem_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]            mem_rsp_tag,
    output logic                                mem_rsp_ready
);

    localparam int DW  = LINE_SIZE * 8;
    localparam int PW  = (PORT_BITS > 0) ? PORT_BITS : 1;
    localparam int RSW = TAG_OUT_WIDTH + DW;

    typedef struct packed {
        logic                       rw;
        logic [LINE_SIZE-1:0]       byteen;
        logic [ADDR_WIDTH-1:0]      addr;
        logic [DW-1:0]              data;
        logic [TAG_OUT_WIDTH-1:0]   tag;
    } req_pkt_t;

    logic                     grant_valid;
    logic [PW-1:0]            grant_idx;
    logic [TAG_OUT_WIDTH-1:0] tag_out;
    logic                     req_push;
    logic                     req_full;
    logic                     req_empty;
    req_pkt_t                 req_in;
    req_pkt_t                 req_head;

    logic [RSW-1:0]           rsp_in;
    logic [RSW-1:0]           rsp_head;
    logic                     rsp_full;
    logic                     rsp_empty;
    logic                     rsp_pop;
    logic [TAG_OUT_WIDTH-1:0] rsp_head_tag;
    logic [DW-1:0]            rsp_head_data;
    logic [PW-1:0]            rsp_port;
    logic [TAG_IN_WIDTH-1:0]  rsp_tag_stripped;
    logic                     rsp_port_ok;

    // ---------------------------------------------------------------- requests
    generate
        if (NUM_PORTS > 1) begin : g_rr
            logic [PW-1:0] rr_ptr;

            // Scan from the farthest offset down so the nearest valid port at
            // or after rr_ptr is the one left standing.
            always_comb begin
                grant_valid = 1'b0;
                grant_idx   = '0;
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    if (in_req_valid[(int'(rr_ptr) + i) % NUM_PORTS]) begin
                        grant_valid = 1'b1;
                        grant_idx   = PW'((int'(rr_ptr) + i) % NUM_PORTS);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rr_ptr <= '0;
                end else if (req_push) begin
                    rr_ptr <= PW'((int'(grant_idx) + 1) % NUM_PORTS);
                end
            end

            assign tag_out = {in_req_tag[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
        end else begin : g_single
            assign grant_valid = in_req_valid[0];
            assign grant_idx   = '0;
            assign tag_out     = in_req_tag;
        end
    endgenerate

    assign req_push = grant_valid && !req_full && !reset;

    always_comb begin
        in_req_ready = '0;
        if (req_push) in_req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        req_in        = '0;
        req_in.rw     = in_req_rw[grant_idx];
        req_in.byteen = in_req_byteen[grant_idx*LINE_SIZE +: LINE_SIZE];
        req_in.addr   = in_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        req_in.data   = in_req_data[grant_idx*DW +: DW];
        req_in.tag    = tag_out;
    end

    vx_elastic_buf2 #(
        .WIDTH ($bits(req_pkt_t))
    ) req_buf (
        .clk        (clk),
        .reset      (reset),
        .push_valid (req_push),
        .push_data  (req_in),
        .pop_ready  (mem_req_ready),
        .pop_data   (req_head),
        .full       (req_full),
        .empty      (req_empty)
    );

    assign mem_req_valid  = !req_empty && !reset;
    assign mem_req_rw     = req_head.rw;
    assign mem_req_byteen = req_head.byteen;
    assign mem_req_addr   = req_head.addr;
    assign mem_req_data   = req_head.data;
    assign mem_req_tag    = req_head.tag;

    // --------------------------------------------------------------- responses
    assign mem_rsp_ready = !rsp_full && !reset;
    assign rsp_in        = {mem_rsp_tag, mem_rsp_data};

    vx_elastic_buf2 #(
        .WIDTH (RSW)
    ) rsp_buf (
        .clk        (clk),
        .reset      (reset),
        .push_valid (mem_rsp_valid && mem_rsp_ready),
        .push_data  (rsp_in),
        .pop_ready  (rsp_pop),
        .pop_data   (rsp_head),
        .full       (rsp_full),
        .empty      (rsp_empty)
    );

    assign rsp_head_tag  = rsp_head[RSW-1:DW];
    assign rsp_head_data = rsp_head[DW-1:0];

    generate
        if (NUM_PORTS > 1) begin : g_rsp_split
            assign rsp_port         = rsp_head_tag[PW-1:0];
            assign rsp_tag_stripped = rsp_head_tag[TAG_OUT_WIDTH-1:PORT_BITS];
        end else begin : g_rsp_pass
            assign rsp_port         = '0;
            assign rsp_tag_stripped = rsp_head_tag;
        end
    endgenerate

    assign rsp_port_ok = (int'(rsp_port) < NUM_PORTS);

    // An unroutable head is dropped so it cannot wedge every port behind it.
    assign rsp_pop = !rsp_port_ok || in_rsp_ready[rsp_port];

    always_comb begin
        in_rsp_valid = '0;
        if (!rsp_empty && !reset && rsp_port_ok) in_rsp_valid[rsp_port] = 1'b1;
    end

    assign in_rsp_data = {NUM_PORTS{rsp_head_data}};
    assign in_rsp_tag  = {NUM_PORTS{rsp_tag_stripped}};

    always_ff @(posedge clk) begin
        if (!reset && !rsp_empty) begin
            rsp_port_range_a: assert (rsp_port_ok);
        end
    end

endmodule

// File: tb/tb_vx_mem_port_arb.sv
// Bench for vx_mem_port_arb with four ports: directed steps followed by a
// randomized phase checked against a queue-based model of the two directions.
module tb_vx_mem_port_arb;

    localparam int NP = 4;
    localparam int LS = 8;
    localparam int AW = 26;
    localparam int TI = 8;
    localparam int PB = 2;
    localparam int TO = TI + PB;
    localparam int DW = LS * 8;
    localparam int PKW = 1 + LS + AW + DW + TO;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     in_req_valid;
    logic [NP-1:0]     in_req_rw;
    logic [NP*LS-1:0]  in_req_byteen;
    logic [NP*AW-1:0]  in_req_addr;
    logic [NP*DW-1:0]  in_req_data;
    logic [NP*TI-1:0]  in_req_tag;
    logic [NP-1:0]     in_req_ready;
    logic [NP-1:0]     in_rsp_valid;
    logic [NP*DW-1:0]  in_rsp_data;
    logic [NP*TI-1:0]  in_rsp_tag;
    logic [NP-1:0]     in_rsp_ready;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [LS-1:0]     mem_req_byteen;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic [TO-1:0]     mem_req_tag;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;
    logic [TO-1:0]     mem_rsp_tag;
    logic              mem_rsp_ready;

    vx_mem_port_arb #(
        .NUM_PORTS    (NP),
        .LINE_SIZE    (LS),
        .ADDR_WIDTH   (AW),
        .TAG_IN_WIDTH (TI)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (in_req_valid),
        .in_req_rw      (in_req_rw),
        .in_req_byteen  (in_req_byteen),
        .in_req_addr    (in_req_addr),
        .in_req_data    (in_req_data),
        .in_req_tag     (in_req_tag),
        .in_req_ready   (in_req_ready),
        .in_rsp_valid   (in_rsp_valid),
        .in_rsp_data    (in_rsp_data),
        .in_rsp_tag     (in_rsp_tag),
        .in_rsp_ready   (in_rsp_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready)
    );

    always #5 clk = ~clk;

    // Per-port upstream request state, packed onto the DUT buses by apply().
    logic          p_valid [NP];
    logic          p_rw    [NP];
    logic [LS-1:0] p_be    [NP];
    logic [AW-1:0] p_addr  [NP];
    logic [DW-1:0] p_data  [NP];
    logic [TI-1:0] p_tag   [NP];

    logic [PKW-1:0]   req_exp_q [$];
    logic [TO+DW-1:0] rsp_exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply();
        for (int p = 0; p < NP; p++) begin
            in_req_valid[p]           = p_valid[p];
            in_req_rw[p]              = p_rw[p];
            in_req_byteen[p*LS +: LS] = p_be[p];
            in_req_addr[p*AW +: AW]   = p_addr[p];
            in_req_data[p*DW +: DW]   = p_data[p];
            in_req_tag[p*TI +: TI]    = p_tag[p];
        end
    endtask

    task automatic new_req(input int p, input logic [TI-1:0] tag);
        p_valid[p] = 1'b1;
        p_rw[p]    = 1'($urandom_range(0, 1));
        p_be[p]    = LS'($urandom);
        p_addr[p]  = AW'($urandom);
        p_data[p]  = {$urandom, $urandom};
        p_tag[p]   = tag;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < NP; p++) p_valid[p] = 1'b0;
    endtask

    // Expected memory-side request for port p: payload as presented, port in tag LSBs.
    function automatic logic [PKW-1:0] pkt_of(input int p);
        return {p_rw[p], p_be[p], p_addr[p], p_data[p], p_tag[p], PB'(p)};
    endfunction

    function automatic logic [PKW-1:0] dut_pkt();
        return {mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag};
    endfunction

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            model_rr;
        int            g;
        int            hp;
        int            rq_size;
        int            rs_size;
        logic [NP-1:0] exp_rdy;
        logic [TO+DW-1:0] head;

        reset         = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_tag   = '0;
        in_rsp_ready  = '0;
        in_req_valid  = '0;
        in_req_rw     = '0;
        in_req_byteen = '0;
        in_req_addr   = '0;
        in_req_data   = '0;
        in_req_tag    = '0;
        for (int p = 0; p < NP; p++) new_req(p, TI'(8'h70 + p));
        apply();

        // Reset held three cycles with every port requesting.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_mem_req_valid", mem_req_valid, 1'b0);
            check("rst_in_req_ready", in_req_ready, 4'b0000);
            check("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
        end
        reset = 1'b0;
        clear_reqs();
        apply();
        tick();
        check("post_rst_mem_rsp_ready", mem_rsp_ready, 1'b1);
        check("post_rst_mem_req_valid", mem_req_valid, 1'b0);

        // All four ports valid continuously: grants rotate 0,1,2,3,...
        for (int p = 0; p < NP; p++) new_req(p, TI'(8'h10 + p));
        apply();
        settle();
        check("rr_first_valid_latency", mem_req_valid, 1'b0);
        check("rr_first_ready", in_req_ready, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_mem_req_valid", mem_req_valid, 1'b1);
            check("rr_mem_req_pkt", dut_pkt(), pkt_of(i % NP));
            check("rr_in_req_ready", in_req_ready, oh((i + 1) % NP));
        end
        clear_reqs();
        apply();
        tick();
        check("rr_drained", mem_req_valid, 1'b0);

        // Lone port 2 request, then the pointer must sit past port 2.
        new_req(2, 8'h5A);
        apply();
        settle();
        check("p2_ready", in_req_ready, 4'b0100);
        tick();
        new_req(0, 8'h11);
        new_req(1, 8'h22);
        new_req(2, 8'h77);
        apply();
        settle();
        check("p2_tag", mem_req_tag, 10'h16A);
        check("wrap_grant_port0", in_req_ready, 4'b0001);
        tick();
        clear_reqs();
        apply();
        settle();
        check("wrap_pkt_port0", dut_pkt(), pkt_of(0));
        tick();
        check("wrap_drained", mem_req_valid, 1'b0);

        // Memory stalled: only two requests fit (pointer is at 1 here).
        mem_req_ready = 1'b0;
        new_req(0, 8'h31);
        new_req(1, 8'h32);
        apply();
        for (int c = 0; c < 5; c++) begin
            settle();
            check("stall_in_req_ready", in_req_ready, (c == 0) ? 4'b0010 : (c == 1) ? 4'b0001 : 4'b0000);
            tick();
        end
        clear_reqs();
        apply();
        mem_req_ready = 1'b1;
        settle();
        check("stall_drain_first", dut_pkt(), pkt_of(1));
        tick();
        check("stall_drain_second", dut_pkt(), pkt_of(0));
        tick();
        check("stall_drain_empty", mem_req_valid, 1'b0);

        // Responses: port 2 blocks port 1 until it accepts.
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        in_rsp_ready  = 4'b0000;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 10'h16A;
        mem_rsp_data  = d1;
        settle();
        check("rsp_ready_empty", mem_rsp_ready, 1'b1);
        tick();
        mem_rsp_tag  = 10'h0C1;
        mem_rsp_data = d2;
        settle();
        check("rsp1_valid", in_rsp_valid, 4'b0100);
        check("rsp1_tag", in_rsp_tag[2*TI +: TI], 8'h5A);
        check("rsp1_data", in_rsp_data[2*DW +: DW], d1);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check("rsp_full_ready", mem_rsp_ready, 1'b0);
        check("rsp1_held_valid", in_rsp_valid, 4'b0100);
        check("rsp1_held_tag", in_rsp_tag[2*TI +: TI], 8'h5A);
        tick();
        in_rsp_ready = 4'b0100;
        settle();
        check("rsp1_still_valid", in_rsp_valid, 4'b0100);
        tick();
        in_rsp_ready = 4'b0000;
        settle();
        check("rsp2_valid", in_rsp_valid, 4'b0010);
        check("rsp2_tag", in_rsp_tag[1*TI +: TI], 8'h30);
        check("rsp2_data", in_rsp_data[1*DW +: DW], d2);
        check("rsp2_ready_reopen", mem_rsp_ready, 1'b1);
        in_rsp_ready = 4'b0010;
        tick();
        in_rsp_ready = 4'b0000;
        settle();
        check("rsp_drained", in_rsp_valid, 4'b0000);

        // Fill both buffers, then reset mid-operation.
        mem_req_ready = 1'b0;
        new_req(0, 8'h41);
        new_req(1, 8'h42);
        apply();
        tick();
        tick();
        clear_reqs();
        apply();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h51, 2'd3};
        mem_rsp_data  = {$urandom, $urandom};
        tick();
        mem_rsp_tag   = {8'h52, 2'd0};
        mem_rsp_data  = {$urandom, $urandom};
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check("prerst_req_valid", mem_req_valid, 1'b1);
        check("prerst_rsp_full", mem_rsp_ready, 1'b0);
        check("prerst_rsp_valid", in_rsp_valid, 4'b1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("midrst_req_valid", mem_req_valid, 1'b0);
        check("midrst_rsp_valid", in_rsp_valid, 4'b0000);
        check("midrst_rsp_ready", mem_rsp_ready, 1'b1);
        new_req(0, 8'h61);
        new_req(1, 8'h62);
        apply();
        settle();
        check("midrst_rr_zero", in_req_ready, 4'b0001);
        mem_req_ready = 1'b1;
        tick();
        clear_reqs();
        apply();
        settle();
        check("midrst_fresh_pkt", dut_pkt(), pkt_of(0));
        tick();
        check("midrst_no_stale", mem_req_valid, 1'b0);

        // Randomized traffic against the queue model, from a clean reset.
        clear_reqs();
        apply();
        in_rsp_ready  = '0;
        mem_rsp_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_rr = 0;
        req_exp_q.delete();
        rsp_exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++)
                if (!p_valid[p] && $urandom_range(0, 1) == 1) new_req(p, TI'($urandom));
            mem_req_ready = ($urandom_range(0, 3) != 0);
            if (!mem_rsp_valid && $urandom_range(0, 2) == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = TO'($urandom);
                mem_rsp_data  = {$urandom, $urandom};
            end
            in_rsp_ready = NP'($urandom_range(0, 15));
            apply();
            settle();

            rq_size = req_exp_q.size();
            rs_size = rsp_exp_q.size();
            g = -1;
            for (int k = NP - 1; k >= 0; k--)
                if (p_valid[(model_rr + k) % NP]) g = (model_rr + k) % NP;
            exp_rdy = (g >= 0 && rq_size < 2) ? oh(g) : '0;
            check("rnd_in_req_ready", in_req_ready, exp_rdy);
            check("rnd_mem_req_valid", mem_req_valid, rq_size > 0);
            if (rq_size > 0) check("rnd_mem_req_pkt", dut_pkt(), req_exp_q[0]);
            check("rnd_mem_rsp_ready", mem_rsp_ready, rs_size < 2);
            hp = -1;
            if (rs_size > 0) begin
                head = rsp_exp_q[0];
                hp = int'(head[DW +: PB]);
                check("rnd_in_rsp_valid", in_rsp_valid, oh(hp));
                check("rnd_in_rsp_tag", in_rsp_tag[hp*TI +: TI], head[DW+PB +: TI]);
                check("rnd_in_rsp_data", in_rsp_data[hp*DW +: DW], head[DW-1:0]);
            end else begin
                check("rnd_in_rsp_idle", in_rsp_valid, 4'b0000);
            end

            if (rq_size > 0 && mem_req_ready) void'(req_exp_q.pop_front());
            if (exp_rdy != '0) begin
                req_exp_q.push_back(pkt_of(g));
                model_rr = (g + 1) % NP;
            end
            if (hp >= 0 && in_rsp_ready[hp]) void'(rsp_exp_q.pop_front());
            if (mem_rsp_valid && rs_size < 2) rsp_exp_q.push_back({mem_rsp_tag, mem_rsp_data});

            tick();
            if (exp_rdy != '0) p_valid[g] = 1'b0;
            if (mem_rsp_valid && rs_size < 2) mem_rsp_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
